// File: rtl/ws2812_frame_driver.sv
// WS2812 strip driver: fetches MAX_POS GRB colours, serialises them, then latches.
// Define WS2812_BRIGHTNESS_LIMIT_EN to capture every channel at quarter brightness.
module ws2812_frame_driver #(
   parameter int MAX_POS   = 16,
   parameter int T0H_CLK   = 20,
   parameter int T1H_CLK   = 40,
   parameter int BIT_CLK   = 63,
   parameter int LATCH_CLK = 3000
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       update_frame,
   input  logic [7:0]                 led_green_intensity,
   input  logic [7:0]                 led_red_intensity,
   input  logic [7:0]                 led_blue_intensity,
   output logic [$clog2(MAX_POS)-1:0] current_led,
   output logic                       leds_line,
   output logic                       busy
);

   localparam int PW = $clog2(MAX_POS);
   localparam int CW = $clog2(BIT_CLK);
   localparam int LW = $clog2(LATCH_CLK);
   localparam int BW = $clog2(24);

   localparam logic [PW-1:0] LED_END = PW'(MAX_POS - 1);
   localparam logic [CW-1:0] CYC_END = CW'(BIT_CLK - 1);
   localparam logic [LW-1:0] LAT_END = LW'(LATCH_CLK - 1);
   localparam logic [BW-1:0] BIT_TOP = BW'(23);

   typedef enum logic [2:0] {IDLE, FETCH, LOAD, SEND, LATCH} state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] led_q, led_d;
   logic [CW-1:0] cyc_q, cyc_d;
   logic [BW-1:0] bit_q, bit_d;
   logic [LW-1:0] lat_q, lat_d;
   logic [23:0]   sh_q, sh_d;
   logic [23:0]   grb;
   logic [CW-1:0] thigh;

`ifdef WS2812_BRIGHTNESS_LIMIT_EN
   assign grb = {2'b00, led_green_intensity[7:2],
                 2'b00, led_red_intensity[7:2],
                 2'b00, led_blue_intensity[7:2]};
`else
   assign grb = {led_green_intensity, led_red_intensity, led_blue_intensity};
`endif

   assign thigh = sh_q[23] ? CW'(T1H_CLK) : CW'(T0H_CLK);

   always_comb begin
      state_d = state_q;
      led_d   = led_q;
      cyc_d   = cyc_q;
      bit_d   = bit_q;
      lat_d   = lat_q;
      sh_d    = sh_q;
      unique case (state_q)
         IDLE: begin
            if (update_frame) begin
               state_d = FETCH;
               led_d   = '0;
            end
         end
         FETCH: state_d = LOAD;
         LOAD: begin
            sh_d    = grb;
            cyc_d   = '0;
            bit_d   = BIT_TOP;
            state_d = SEND;
         end
         SEND: begin
            if (cyc_q == CYC_END) begin
               cyc_d = '0;
               sh_d  = {sh_q[22:0], 1'b0};
               // bit 0 done: move to the next LED or close the frame
               if (bit_q == '0) begin
                  if (led_q == LED_END) begin
                     state_d = LATCH;
                     led_d   = '0;
                     lat_d   = '0;
                  end else begin
                     state_d = FETCH;
                     led_d   = led_q + 1'b1;
                  end
               end else begin
                  bit_d = bit_q - 1'b1;
               end
            end else begin
               cyc_d = cyc_q + 1'b1;
            end
         end
         LATCH: begin
            if (lat_q == LAT_END) state_d = IDLE;
            else                  lat_d   = lat_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         led_q   <= '0;
         cyc_q   <= '0;
         bit_q   <= '0;
         lat_q   <= '0;
         sh_q    <= '0;
      end else begin
         state_q <= state_d;
         led_q   <= led_d;
         cyc_q   <= cyc_d;
         bit_q   <= bit_d;
         lat_q   <= lat_d;
         sh_q    <= sh_d;
      end
   end

   assign current_led = led_q;
   assign busy        = (state_q != IDLE);
   assign leds_line   = (state_q == SEND) && (cyc_q < thigh);

endmodule

// File: tb/tb_ws2812_frame_driver.sv
// Bench for ws2812_frame_driver: random colours against a timeline model of the line.
// Build with WS2812_BRIGHTNESS_LIMIT_EN to cover the quarter-brightness variant.
`timescale 1ns/1ps
module tb_ws2812_frame_driver;

   localparam int MAXP  = 4;
   localparam int T0    = 20;
   localparam int T1    = 40;
   localparam int BITC  = 63;
   localparam int LAT   = 3000;
   localparam int LEDP  = 24 * BITC + 2;
   localparam int FRAME = MAXP * LEDP + LAT;

`ifdef WS2812_BRIGHTNESS_LIMIT_EN
   localparam logic [23:0] LIT_IN  = 24'hFF8003;
   localparam logic [23:0] LIT_EXP = 24'h3F2000;
`else
   localparam logic [23:0] LIT_IN  = 24'hFF00A5;
   localparam logic [23:0] LIT_EXP = 24'hFF00A5;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       update_frame;
   logic [7:0] g, r, b;
   logic [1:0] cur;
   logic       line;
   logic       busy;

   always #5 clk = ~clk;

   ws2812_frame_driver #(
      .MAX_POS(MAXP), .T0H_CLK(T0), .T1H_CLK(T1),
      .BIT_CLK(BITC), .LATCH_CLK(LAT)
   ) dut (
      .clk(clk),
      .reset(reset),
      .update_frame(update_frame),
      .led_green_intensity(g),
      .led_red_intensity(r),
      .led_blue_intensity(b),
      .current_led(cur),
      .leds_line(line),
      .busy(busy)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [23:0] xf(input logic [23:0] c);
`ifdef WS2812_BRIGHTNESS_LIMIT_EN
      return {2'b00, c[23:18], 2'b00, c[15:10], 2'b00, c[7:2]};
`else
      return c;
`endif
   endfunction

   logic [23:0] col [MAXP];
   logic [23:0] dq [$];
   logic [23:0] dec;
   int  n = 0, t0 = 0, hi_len = 0, dcnt = 0;
   int  line_err = 0, busy_err = 0, cur_err = 0;
   bit  act = 1'b0;

   // Timeline model: frame = MAXP slots of (2 low + 24 bits), then LAT low.
   always @(negedge clk) begin
      int rel, k, p, bi, ph;
      logic e_line, e_busy, e_load;
      logic [23:0] w;
      int e_cur;
      n++;
      e_line = 1'b0; e_busy = 1'b0; e_load = 1'b0; e_cur = 0;
      if (reset !== 1'b1) act = 1'b0;
      if (act) begin
         rel = n - t0;
         if (rel >= FRAME) begin
            act = 1'b0;
         end else begin
            e_busy = 1'b1;
            if (rel < MAXP * LEDP) begin
               k = rel / LEDP;
               p = rel % LEDP;
               e_cur  = k;
               e_load = (p == 1);
               if (p >= 2) begin
                  bi = (p - 2) / BITC;
                  ph = (p - 2) % BITC;
                  w  = xf(col[k]);
                  e_line = (ph < (w[23-bi] ? T1 : T0));
               end
            end
         end
      end
      if (line !== e_line) line_err++;
      if (busy !== e_busy) busy_err++;
      if (cur !== 2'(e_cur)) cur_err++;
      if (reset !== 1'b1) begin
         hi_len = 0;
         dcnt   = 0;
      end else if (line === 1'b1) begin
         hi_len++;
      end else if (hi_len > 0) begin
         dec    = {dec[22:0], (hi_len > (T0 + T1) / 2)};
         hi_len = 0;
         dcnt++;
         if (dcnt == 24) begin
            dq.push_back(dec);
            dcnt = 0;
         end
      end
      if (e_load) {g, r, b} = col[cur];
      else        {g, r, b} = 24'($urandom);
      if (!act && reset === 1'b1 && update_frame === 1'b1) begin
         act = 1'b1;
         t0  = n + 1;
      end
   end

   task automatic clr_errs();
      line_err = 0; busy_err = 0; cur_err = 0;
      dq.delete();
   endtask

   task automatic chk_errs(input string tag);
      check($sformatf("%s_line", tag), line_err, 0);
      check($sformatf("%s_busy", tag), busy_err, 0);
      check($sformatf("%s_cur", tag), cur_err, 0);
   endtask

   task automatic chk_words(input string tag, input int nf);
      check($sformatf("%s_nwords", tag), dq.size(), nf * MAXP);
      for (int i = 0; i < nf * MAXP; i++)
         if (i < dq.size())
            check($sformatf("%s_word%0d", tag, i), dq[i], xf(col[i % MAXP]));
   endtask

   task automatic pulse();
      @(posedge clk); #2 update_frame = 1'b1;
      @(posedge clk); #2 update_frame = 1'b0;
   endtask

   task automatic do_frame(input string tag, input bit mid,
                           output logic [23:0] w0);
      clr_errs();
      pulse();
      if (mid) begin
         repeat (2000) @(posedge clk);
         pulse();
         repeat (FRAME - 2000 + 60) @(posedge clk);
      end else begin
         repeat (FRAME + 60) @(posedge clk);
      end
      #2;
      chk_errs(tag);
      chk_words(tag, 1);
      check($sformatf("%s_end_busy", tag), busy, 0);
      w0 = (dq.size() > 0) ? dq[0] : 24'h0;
   endtask

   initial begin
      logic [23:0] w0;
      int tgt;
      reset = 1'b0;
      update_frame = 1'b0;
      g = '0; r = '0; b = '0;
      for (int i = 0; i < MAXP; i++) col[i] = '0;

      repeat (3) @(posedge clk); #2;
      check("rst_line", line, 0);
      check("rst_busy", busy, 0);
      check("rst_cur", cur, 0);
      update_frame = 1'b1;
      @(posedge clk); #2 update_frame = 1'b0;
      check("rst_upd_busy", busy, 0);
      check("rst_upd_line", line, 0);
      repeat (2) @(posedge clk); #2 reset = 1'b1;
      clr_errs();
      repeat (30) @(posedge clk); #2;
      chk_errs("post_rst");

      for (int i = 0; i < MAXP; i++) col[i] = LIT_IN;
      do_frame("lit", 1'b0, w0);
      check("lit_word", w0, LIT_EXP);

      for (int f = 0; f < 2; f++) begin
         for (int i = 0; i < MAXP; i++) col[i] = 24'($urandom);
         do_frame($sformatf("rnd%0d", f), f == 1, w0);
      end

      for (int i = 0; i < MAXP; i++) col[i] = 24'($urandom);
      clr_errs();
      @(posedge clk); #2 update_frame = 1'b1;
      repeat (FRAME + 20) @(posedge clk);
      #2 update_frame = 1'b0;
      repeat (FRAME + 60) @(posedge clk);
      #2;
      chk_errs("b2b");
      chk_words("b2b", 2);
      check("b2b_end_busy", busy, 0);

      for (int i = 0; i < MAXP; i++) col[i] = 24'($urandom);
      clr_errs();
      pulse();
      tgt = t0 + 2 * LEDP + 2 + 10 * BITC + 5;
      for (int i = 0; i < FRAME && n < tgt; i++) begin
         @(posedge clk); #2;
      end
      check("pre_rst_line", line, 1);
      reset = 1'b0;
      #1;
      check("rst_drop_line", line, 0);
      check("rst_drop_busy", busy, 0);
      check("rst_drop_cur", cur, 0);
      repeat (5) @(posedge clk);
      #2 reset = 1'b1;
      repeat (LAT + 200) @(posedge clk);
      #2;
      chk_errs("abort");
      check("abort_line", line, 0);
      check("abort_busy", busy, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
